vga_glyph_renderer: RTL and testbench
=====================================

VGA_GLYPH_RENDERER -- requirements
Module: vga_glyph_renderer

Interface
REQ-001 Parameter COLS, default 20: text columns per row.
REQ-002 Parameter ROWS, default 4: text rows per frame.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 frame_start  in  1  one-cycle pulse before the first active line of a frame.
REQ-006 line_start  in  1  one-cycle pulse at least 3 cycles before the first pix_en of an active line.
REQ-007 pix_en  in  1  pixel strobe; at most one per cycle; consecutive cycles allowed.
REQ-008 char_addr  out  $clog2(COLS*ROWS)  text-buffer address, row*COLS+col.
REQ-009 char_code  in  7  text-buffer data, valid exactly 1 cycle after char_addr.
REQ-010 glyph_addr  out  7  glyph ROM address, equal to the last captured char_code.
REQ-011 glyph_data  in  35  glyph ROM data, combinational from glyph_addr.
REQ-012 pixel  out  1  rendered pixel (1 = foreground).
REQ-013 pixel_valid  out  1  high for one cycle when pixel is updated.

Function
REQ-014 Cell is 6x8 pixels: glyph columns 0-4 and rows 0-6; column 5 and row 7 are blank (0).
REQ-015 Glyph pixel (r,c) SHALL be glyph_data[34-5*r-c], r in 0..6, c in 0..4.
REQ-016 Counters: glyph_row 0..7, text_row 0..ROWS-1(+overflow), pix_col 0..5, text_col 0..COLS.
REQ-017 frame_start clears glyph_row and text_row and arms a first-line flag.
REQ-018 line_start: if first-line flag is set, clear it without advancing; otherwise increment glyph_row, wrapping 7->0 with text_row+1.
REQ-019 line_start clears pix_col and text_col and starts the prefetch of column 0.
REQ-020 Prefetch FSM states: IDLE, ADDR (char_addr driven), DATA (char_code captured into glyph_addr), HOLD (5-bit row slice latched into next-cell register).
REQ-021 Transitions: IDLE->ADDR on line_start or cell consumption; ADDR->DATA->HOLD, one cycle each; HOLD->ADDR when the current cell's first pixel is issued and the next column < COLS; otherwise HOLD->IDLE.
REQ-022 On pix_col==0, the next-cell register transfers into the shift register; each pix_en emits one bit, MSB (c=0) first, then increments pix_col (wrap 5->0, text_col+1).
REQ-023 Latency: pixel and pixel_valid SHALL assert exactly 1 cycle after each pix_en.
REQ-024 text_row>=ROWS, text_col>=COLS or glyph_row==7: pixel=0, no char_addr update, FSM stays IDLE.
REQ-025 pix_en without a preceding line_start in the frame emits pixel=0 with pixel_valid=1.
REQ-026 line_start coinciding with pix_en: line_start wins; that pix_en emits 0.
REQ-027 frame_start coinciding with line_start: frame_start applied first, so the line renders glyph_row 0, text_row 0.
REQ-028 char_addr and glyph_addr hold their value between fetches.

Reset
REQ-029 rst SHALL clear all counters, the FSM (to IDLE), and the shift and next-cell registers; it SHALL clear the first-line flag and set pixel, pixel_valid, char_addr and glyph_addr to 0.
REQ-030 rst asserted mid-line SHALL abort the line; pixel_valid SHALL be 0 until the next pix_en after rst deasserts.

Configuration
REQ-031 Macro VGACON_CURSOR_EN: when defined, add input cursor_addr ($clog2(COLS*ROWS)) and a 5-bit frame counter, incremented on frame_start.
REQ-032 With the macro, every pixel of the cell whose address equals cursor_addr SHALL be inverted, including the blank column and row, while counter bit 4 is 1.
REQ-033 Without the macro, the port and counter are absent and pixels are never inverted.

Verification
REQ-034 rst, then frame_start, line_start, char_code=0x41, glyph_data=35'h4_0000_0000, 6 pix_en -> pixel sequence 1,0,0,0,0,0; the 1 appears 1 cycle after the first pix_en.
REQ-035 pix_en every cycle for COLS*6 pixels, with char_code=col -> char_addr steps 0..19; every cell emits its row slice with no gap or stall.
REQ-036 8 line_starts after frame_start with glyph_data all ones -> lines 0-6 give 11111 0 per cell; line 7 gives all 0; the 9th line fetches char_addr=20.
REQ-037 Line with text_row=ROWS (33rd line) -> all pixels 0; char_addr unchanged.
REQ-038 rst pulsed after 3 pixels of a line -> pixel_valid=0 next cycle; next frame renders correctly from char_addr 0.
REQ-039 VGACON_CURSOR_EN, cursor_addr=2, 16 frame_starts -> cell 2 inverted (blank column 5 reads 1); cells 1 and 3 unaffected; 32 frames -> inversion off.

Source files
------------

// File: rtl/vga_glyph_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_glyph_renderer_if
// Purpose  : Bundles the timing strobes, text-buffer fetch, glyph-ROM lookup
//            and pixel output of the glyph renderer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   frame_start  one-cycle pulse before the first active line of a frame
//   line_start   one-cycle pulse >= 3 cycles before the first pix_en of a line
//   pix_en       pixel strobe
//   char_addr    text-buffer address (row*COLS+col)
//   char_code    text-buffer data, valid one cycle after char_addr
//   glyph_addr   glyph ROM address (last captured char_code)
//   glyph_data   glyph ROM data, combinational from glyph_addr
//   pixel        rendered pixel, 1 = foreground
//   pixel_valid  one-cycle strobe marking a new pixel
//   cursor_addr  cursor cell address (only with VGACON_CURSOR_EN)
// Modports: master = timing/memory side, slave = renderer.
// Configuration macro: VGACON_CURSOR_EN
// ============================================================================
interface vga_glyph_renderer_if #(
    parameter int COLS = 20,
    parameter int ROWS = 4
);
    localparam int c_addr_w = $clog2(COLS * ROWS);

    logic                frame_start;
    logic                line_start;
    logic                pix_en;
    logic [c_addr_w-1:0] char_addr;
    logic [6:0]          char_code;
    logic [6:0]          glyph_addr;
    logic [34:0]         glyph_data;
    logic                pixel;
    logic                pixel_valid;
`ifdef VGACON_CURSOR_EN
    logic [c_addr_w-1:0] cursor_addr;

    modport master (
        output frame_start, line_start, pix_en, char_code, glyph_data, cursor_addr,
        input  char_addr, glyph_addr, pixel, pixel_valid
    );
    modport slave (
        input  frame_start, line_start, pix_en, char_code, glyph_data, cursor_addr,
        output char_addr, glyph_addr, pixel, pixel_valid
    );
`else
    modport master (
        output frame_start, line_start, pix_en, char_code, glyph_data,
        input  char_addr, glyph_addr, pixel, pixel_valid
    );
    modport slave (
        input  frame_start, line_start, pix_en, char_code, glyph_data,
        output char_addr, glyph_addr, pixel, pixel_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/vga_glyph_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_glyph_renderer
// Purpose  : Character-cell text renderer. Cells are 6x8 pixels: a 5x7 glyph
//            from a 35-bit ROM word plus a blank column 5 and blank row 7.
//            A four-state prefetch FSM fetches the next cell's character code
//            and glyph row slice while the current cell is being shifted out.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   vga_glyph_renderer_if.slave (strobes, fetch, glyph ROM, pixel out)
// Parameters
//   COLS  text columns per row (default 20)
//   ROWS  text rows per frame  (default 4)
// Configuration macro: VGACON_CURSOR_EN adds cursor_addr and a 5-bit frame
//   counter; the cursor cell is inverted while counter bit 4 is set.
// ============================================================================
module vga_glyph_renderer #(
    parameter int COLS = 20,
    parameter int ROWS = 4
) (
    input logic                 clk,
    input logic                 rst,
    vga_glyph_renderer_if.slave bus
);
    localparam int c_addr_w = $clog2(COLS * ROWS);
    localparam int c_col_w  = $clog2(COLS + 1);
    localparam int c_row_w  = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_glyph_row;
    logic [c_row_w-1:0]  r_text_row;
    logic [2:0]          r_pix_col;
    logic [c_col_w-1:0]  r_text_col;
    logic                r_first_line;
    logic                r_line_active;
    logic [4:0]          r_shift;
    logic [4:0]          r_next;
    logic [c_addr_w-1:0] r_char_addr;
    logic [6:0]          r_glyph_addr;
    logic                r_pixel;
    logic                r_pixel_valid;

    // Line position that a line_start in this cycle would establish.
    // frame_start is folded in first so a coincident pair renders row 0.
    logic                w_first;
    logic [2:0]          w_base_grow;
    logic [c_row_w-1:0]  w_base_trow;
    logic [2:0]          w_new_grow;
    logic [c_row_w-1:0]  w_new_trow;
    logic                w_new_blank;
    logic [c_addr_w-1:0] w_line_addr;

    always_comb begin
        w_first     = bus.frame_start | r_first_line;
        w_base_grow = bus.frame_start ? 3'd0 : r_glyph_row;
        w_base_trow = bus.frame_start ? '0   : r_text_row;
        w_new_grow  = w_base_grow;
        w_new_trow  = w_base_trow;
        if (!w_first) begin
            if (w_base_grow == 3'd7) begin
                w_new_grow = 3'd0;
                // text_row saturates at ROWS: everything past it is blank
                if (w_base_trow < c_row_w'(ROWS)) begin
                    w_new_trow = w_base_trow + c_row_w'(1);
                end
            end else begin
                w_new_grow = w_base_grow + 3'd1;
            end
        end
        w_new_blank = (w_new_trow >= c_row_w'(ROWS)) || (w_new_grow == 3'd7);
        w_line_addr = c_addr_w'(w_new_trow * COLS);
    end

    // Row slice of the glyph currently addressed; MSB is glyph column 0.
    logic [4:0] w_slice;

    always_comb begin
        case (r_glyph_row)
            3'd0:    w_slice = bus.glyph_data[34:30];
            3'd1:    w_slice = bus.glyph_data[29:25];
            3'd2:    w_slice = bus.glyph_data[24:20];
            3'd3:    w_slice = bus.glyph_data[19:15];
            3'd4:    w_slice = bus.glyph_data[14:10];
            3'd5:    w_slice = bus.glyph_data[9:5];
            3'd6:    w_slice = bus.glyph_data[4:0];
            default: w_slice = 5'd0;
        endcase
    end

    logic       w_cell_ok;
    logic       w_draw;
    logic       w_pix_step;
    logic       w_consume;
    logic [4:0] w_load;
    logic       w_base_pix;
    logic       w_invert;
    logic       w_pix_out;

    // w_cell_ok: the pixel lies inside the text area of an active line.
    // w_draw additionally excludes the blank glyph row 7.
    assign w_cell_ok  = r_line_active && (r_text_row < c_row_w'(ROWS))
                        && (r_text_col < c_col_w'(COLS));
    assign w_draw     = w_cell_ok && (r_glyph_row != 3'd7);
    // line_start takes priority over a coincident pix_en
    assign w_pix_step = bus.pix_en && !bus.line_start;
    assign w_consume  = w_pix_step && w_draw && (r_pix_col == 3'd0);
    // The first pixel of a cell can arrive in the same cycle the FSM reaches
    // HOLD, before the next-cell register has latched, so bypass it then.
    assign w_load     = (r_state == ST_HOLD) ? w_slice : r_next;
    assign w_base_pix = w_draw ? ((r_pix_col == 3'd0) ? w_load[4] : r_shift[4]) : 1'b0;
    assign w_pix_out  = w_pix_step && (w_base_pix ^ w_invert);

`ifdef VGACON_CURSOR_EN
    logic [4:0]          r_frame_cnt;
    logic [c_addr_w-1:0] w_cell_addr;

    assign w_cell_addr = c_addr_w'(r_text_row * COLS + r_text_col);
    // Inversion covers the whole 6x8 cell, blank column and row included.
    assign w_invert    = w_cell_ok && r_frame_cnt[4] && (w_cell_addr == bus.cursor_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 5'd0;
        end else if (bus.frame_start) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end
`else
    assign w_invert = 1'b0;
`endif

    // Line/cell counters, shift register and pixel output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glyph_row   <= 3'd0;
            r_text_row    <= '0;
            r_pix_col     <= 3'd0;
            r_text_col    <= '0;
            r_first_line  <= 1'b0;
            r_line_active <= 1'b0;
            r_shift       <= 5'd0;
            r_pixel       <= 1'b0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= bus.pix_en;
            if (bus.pix_en) begin
                r_pixel <= w_pix_out;
            end

            if (bus.line_start) begin
                r_glyph_row   <= w_new_grow;
                r_text_row    <= w_new_trow;
                r_first_line  <= 1'b0;
                r_line_active <= 1'b1;
                r_pix_col     <= 3'd0;
                r_text_col    <= '0;
            end else begin
                if (bus.frame_start) begin
                    r_glyph_row   <= 3'd0;
                    r_text_row    <= '0;
                    r_first_line  <= 1'b1;
                    r_line_active <= 1'b0;
                end
                if (w_pix_step && w_cell_ok) begin
                    if (r_pix_col == 3'd5) begin
                        r_pix_col  <= 3'd0;
                        r_text_col <= r_text_col + c_col_w'(1);
                    end else begin
                        r_pix_col <= r_pix_col + 3'd1;
                    end
                    // Zero-fill means column 5 shifts out as blank.
                    if (w_draw) begin
                        r_shift <= (r_pix_col == 3'd0) ? {w_load[3:0], 1'b0}
                                                       : {r_shift[3:0], 1'b0};
                    end
                end
            end
        end
    end

    // Prefetch FSM: ADDR presents char_addr, DATA captures char_code into
    // glyph_addr, HOLD keeps the row slice until the held cell starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_char_addr  <= '0;
            r_glyph_addr <= 7'd0;
            r_next       <= 5'd0;
        end else if (bus.line_start) begin
            if (w_new_blank) begin
                r_state <= ST_IDLE;
            end else begin
                r_state     <= ST_ADDR;
                r_char_addr <= w_line_addr;
            end
        end else if (bus.frame_start) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDR: r_state <= ST_DATA;
                ST_DATA: begin
                    r_glyph_addr <= bus.char_code;
                    r_state      <= ST_HOLD;
                end
                ST_HOLD: begin
                    r_next <= w_slice;
                    if (w_consume) begin
                        if (r_text_col < c_col_w'(COLS - 1)) begin
                            r_char_addr <= r_char_addr + c_addr_w'(1);
                            r_state     <= ST_ADDR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.char_addr   = r_char_addr;
    assign bus.glyph_addr  = r_glyph_addr;
    assign bus.pixel       = r_pixel;
    assign bus.pixel_valid = r_pixel_valid;

endmodule
`default_nettype wire

// File: tb/tb_vga_glyph_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_glyph_renderer
// Purpose  : Scoreboard bench for vga_glyph_renderer. Stimulus pushes the
//            expected pixel and its due cycle; a monitor pops on pixel_valid.
// Revision : 1.0 - initial release
// Configuration macro: VGACON_CURSOR_EN enables the cursor scenario.
// ============================================================================
module tb_vga_glyph_renderer;
    localparam int COLS = 20;
    localparam int ROWS = 4;
    localparam int AW   = $clog2(COLS * ROWS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_glyph_renderer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    vga_glyph_renderer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Text buffer (1-cycle read latency) and combinational glyph ROM.
    logic [6:0]  tmem [0:COLS*ROWS-1];
    logic [34:0] grom [0:127];

    always @(posedge clk) bus.char_code <= tmem[bus.char_addr];
    assign bus.glyph_data = grom[bus.glyph_addr];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic val;
        int   due;
        int   tag;
    } exp_t;
    exp_t q[$];

    // Monitor: every pixel_valid must match the queue head, in its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.pixel_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pixel cyc=%0d got=%b", cyc, bus.pixel);
            end else begin
                e = q.pop_front();
                if (bus.pixel !== e.val || cyc != e.due) begin
                    failures++;
                    $display("FAIL pixel tag=%0d got=%b@%0d want=%b@%0d",
                             e.tag, bus.pixel, cyc, e.val, e.due);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_pixel tag=%0d want=%b@%0d", e.tag, e.val, e.due);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push(input logic v, input int tag);
        exp_t e;
        e.val = v;
        e.due = cyc + 1;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic drive(input logic fs, input logic ls, input logic pe);
        bus.frame_start = fs;
        bus.line_start  = ls;
        bus.pix_en      = pe;
        @(posedge clk);
        #1;
    endtask

    // line_start (optionally with frame_start / a colliding pix_en that must
    // emit 0), then two idle cycles so pixels may follow immediately.
    task automatic start_line(input logic fs, input logic pe, input int tag);
        if (pe) push(1'b0, tag);
        drive(fs, 1'b1, pe);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Reference pixel: glyph bit 34-5r-c, blank column 5 / row 7, cursor xor.
    function automatic logic exp_pix(input int trow, input int grow, input int col,
                                     input int pc, input logic inv_on, input int cur);
        logic [34:0] g;
        logic        b;
        if (trow >= ROWS || col >= COLS) return 1'b0;
        b = 1'b0;
        if (grow < 7 && pc < 5) begin
            g = grom[tmem[trow*COLS + col]];
            b = g[34 - 5*grow - pc];
        end
        if (inv_on && (trow*COLS + col) == cur) b = ~b;
        return b;
    endfunction

    task automatic pixels(input int n, input int trow, input int grow,
                          input logic inv_on, input int cur, input int tag);
        for (int i = 0; i < n; i++) begin
            push(exp_pix(trow, grow, i / 6, i % 6, inv_on, cur), tag);
            drive(1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Pixels with a fixed per-cell pattern (bit 5 = column 0).
    task automatic pixels_pat(input int n, input logic [5:0] pat, input int tag);
        for (int i = 0; i < n; i++) begin
            push(pat[5 - (i % 6)], tag);
            drive(1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_hash();
        for (int k = 0; k < 128; k++) grom[k] = {3'(k) ^ 3'd5, 32'(k) * 32'h9E3779B1};
        for (int k = 0; k < COLS*ROWS; k++) tmem[k] = 7'(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.pix_en      = 1'b0;
`ifdef VGACON_CURSOR_EN
        bus.cursor_addr = AW'(2);
`endif
        for (int k = 0; k < 128; k++) grom[k] = 35'd0;
        for (int k = 0; k < COLS*ROWS; k++) tmem[k] = 7'd0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        check("rst_pixel_valid", 64'(bus.pixel_valid), 64'd0);
        check("rst_pixel",       64'(bus.pixel),       64'd0);
        check("rst_char_addr",   64'(bus.char_addr),   64'd0);
        check("rst_glyph_addr",  64'(bus.glyph_addr),  64'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // pix_en with no line_start: valid 0 pixel, also right after frame_start
        push(1'b0, 1); drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        push(1'b0, 2); drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // 'A' with only glyph bit 34 set -> 1,0,0,0,0,0
        tmem[0] = 7'h41;
        tmem[1] = 7'h33;
        grom[7'h41] = 35'h4_0000_0000;
        drive(1'b1, 1'b0, 1'b0);
        start_line(1'b0, 1'b0, 3);
        pixels_pat(6, 6'b100000, 3);
        check("a_char_addr_prefetch", 64'(bus.char_addr), 64'd1);
        check("a_glyph_addr_prefetch", 64'(bus.glyph_addr), 64'h33);

        // Full line at full rate, frame_start coinciding with line_start
        fill_hash();
        start_line(1'b1, 1'b0, 4);
        pixels(COLS*6 + 6, 0, 0, 1'b0, 0, 4);
        check("fullline_char_addr", 64'(bus.char_addr), 64'(COLS - 1));
        check("fullline_glyph_addr", 64'(bus.glyph_addr), 64'(COLS - 1));

        // All-ones glyphs across 33 lines
        for (int k = 0; k < 128; k++) grom[k] = {35{1'b1}};
        drive(1'b1, 1'b0, 1'b0);
        for (int l = 0; l < 33; l++) begin
            start_line(1'b0, (l == 1), 100 + l);
            if (l == 7)  check("row7_char_addr_hold", 64'(bus.char_addr), 64'd2);
            if (l == 8)  check("line9_char_addr", 64'(bus.char_addr), 64'd20);
            if (l == 32) check("row_overflow_char_addr", 64'(bus.char_addr), 64'd60);
            if (l <= 8 || l == 32) begin
                if (l == 7 || l == 32) pixels_pat(12, 6'b000000, 100 + l);
                else                   pixels_pat(12, 6'b111110, 100 + l);
            end
        end

        // Reset mid-line
        fill_hash();
        start_line(1'b1, 1'b0, 200);
        for (int i = 0; i < 3; i++) begin
            push(exp_pix(0, 0, 0, i, 1'b0, 0), 200);
            drive(1'b0, 1'b0, 1'b1);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        check("midrst_pixel_valid", 64'(bus.pixel_valid), 64'd0);
        check("midrst_char_addr",   64'(bus.char_addr),   64'd0);
        push(1'b0, 201); drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        start_line(1'b1, 1'b0, 202);
        pixels(18, 0, 0, 1'b0, 0, 202);
        check("postrst_char_addr", 64'(bus.char_addr), 64'd3);

`ifdef VGACON_CURSOR_EN
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (15) drive(1'b1, 1'b0, 1'b0);
        start_line(1'b1, 1'b0, 300);
        pixels(24, 0, 0, 1'b1, 2, 300);
        repeat (15) drive(1'b1, 1'b0, 1'b0);
        start_line(1'b1, 1'b0, 301);
        pixels(24, 0, 0, 1'b0, 2, 301);
`endif

        repeat (4) drive(1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
